piso_bit_serializer: RTL and testbench

- Parallel-in, serial-out framer that feeds the serial sequence detectors (e.g. the 11001 Mealy detector) one bit per clock on a single-bit stream.
- Accepts WIDTH-bit words over a valid/ready handshake and double-buffers them, one word in the shifter and one in a holding register, so back-to-back words stream with no idle gap.
- When no data is pending it drives a constant idle bit.

---
 rtl/ser_pkg.sv | 16 +
 rtl/piso_bit_serializer.sv | 121 ++++++++++++
 tb/tb_piso_bit_serializer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer and the sequence-detector benches.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_WIDTH_DEFAULT = 8;

  // Bit-counter width; a single bit is kept even for degenerate widths.
  function automatic int ser_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out framer: shifter plus one holding register so consecutive
// words stream with no idle gap; idle fill bit when nothing is pending.
module piso_bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int              CNT_W    = ser_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             word_done_q, word_done_d;

  logic accept;
  logic last_bit;

  // The shifter always emits from its top bit, so LSB-first words are reversed on load.
  function automatic logic [WIDTH-1:0] to_shift_order(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

  assign load_ready = ~hold_full_q;
  assign busy       = (state_q == SHIFT) | hold_full_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign word_done  = word_done_q;

  assign accept   = load_valid & ~hold_full_q;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = to_shift_order(data_in);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          shreg_d     = to_shift_order(hold_q);
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          shreg_d = to_shift_order(data_in);
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with the shifter.
    dout_valid_d = (state_d == SHIFT);
    dout_d       = dout_valid_d ? shreg_d[WIDTH-1] : IDLE_BIT;
    word_done_d  = dout_valid_d && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      word_done_q  <= word_done_d;
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: three instances (5-bit MSB-first, 8-bit MSB-first,
// 8-bit LSB-first) checked every cycle against a pending-bit queue model.
module tb_piso_bit_serializer;

  localparam int W   [3] = '{5, 8, 8};
  localparam bit MSB [3] = '{1'b1, 1'b1, 1'b0};

  logic       clk;
  logic       rst;
  logic [2:0] lv;
  logic [7:0] din [3];
  logic [2:0] lr, dout, dv, wd, by;

  // Model: pending bits, front (bit 0) is the bit that must be on dout now.
  logic [31:0] mbits [3];
  logic [31:0] mlast [3];
  int          mcnt  [3];

  // Recorded payload stream per instance.
  logic [63:0] rec    [3];
  int          reccnt [3];
  int          wdcnt  [3];
  logic [4:0]  det5;
  int          hits;

  int nchk;
  int nfail;

  piso_bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut5 (
    .clk(clk), .rst(rst), .data_in(din[0][4:0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .dout(dout[0]), .dout_valid(dv[0]), .word_done(wd[0]), .busy(by[0]));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut8 (
    .clk(clk), .rst(rst), .data_in(din[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .dout(dout[1]), .dout_valid(dv[1]), .word_done(wd[1]), .busy(by[1]));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut8l (
    .clk(clk), .rst(rst), .data_in(din[2]), .load_valid(lv[2]), .load_ready(lr[2]),
    .dout(dout[2]), .dout_valid(dv[2]), .word_done(wd[2]), .busy(by[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one bit leaves per clock, an accepted word appends W bits,
  // and a word can be accepted whenever at most one word's worth is still pending.
  always @(posedge clk or negedge rst) begin : model
    logic [31:0] nb, nl;
    int          nc;
    logic        acc;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        mbits[i] <= '0;
        mlast[i] <= '0;
        mcnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        nb  = mbits[i];
        nl  = mlast[i];
        nc  = mcnt[i];
        acc = lv[i] && (nc <= W[i]);
        if (nc > 0) begin
          nb = nb >> 1;
          nl = nl >> 1;
          nc = nc - 1;
        end
        if (acc) begin
          for (int b = 0; b < W[i]; b++) begin
            nb[nc+b] = MSB[i] ? din[i][W[i]-1-b] : din[i][b];
            nl[nc+b] = (b == W[i] - 1);
          end
          nc = nc + W[i];
        end
        mbits[i] <= nb;
        mlast[i] <= nl;
        mcnt[i]  <= nc;
      end
    end
  end

  // Per-cycle compare and stream capture, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dout%0d", i),       {31'd0, dout[i]}, {31'd0, (mcnt[i] > 0) ? mbits[i][0] : 1'b0});
      chk($sformatf("dout_valid%0d", i), {31'd0, dv[i]},   {31'd0, mcnt[i] > 0});
      chk($sformatf("word_done%0d", i),  {31'd0, wd[i]},   {31'd0, (mcnt[i] > 0) && mlast[i][0]});
      chk($sformatf("load_ready%0d", i), {31'd0, lr[i]},   {31'd0, mcnt[i] <= W[i]});
      chk($sformatf("busy%0d", i),       {31'd0, by[i]},   {31'd0, mcnt[i] > 0});
      if (dv[i]) begin
        rec[i]    <= {rec[i][62:0], dout[i]};
        reccnt[i] <= reccnt[i] + 1;
      end
      if (wd[i]) wdcnt[i] <= wdcnt[i] + 1;
    end
    if (dv[0]) begin
      det5 <= {det5[3:0], dout[0]};
      if ({det5[3:0], dout[0]} == 5'b11001) hits <= hits + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s_cnt, s_wd, k, cyc;
    logic rdy;
    logic [7:0] w3 [3];
    nchk = 0;
    nfail = 0;
    for (int i = 0; i < 3; i++) begin
      rec[i] = '0; reccnt[i] = 0; wdcnt[i] = 0; din[i] = '0;
    end
    det5 = '0;
    hits = 0;
    lv   = '0;
    rst  = 1'b0;
    #12;
    chk("rst_dout",  {29'd0, dout}, 32'd0);
    chk("rst_dv",    {29'd0, dv},   32'd0);
    chk("rst_wd",    {29'd0, wd},   32'd0);
    chk("rst_busy",  {29'd0, by},   32'd0);
    chk("rst_ready", {29'd0, lr},   32'd7);
    rst = 1'b1;

    // Single 5-bit word 11001 feeding a downstream 11001 detector.
    tick(1);
    s_cnt = reccnt[0]; s_wd = wdcnt[0];
    lv[0] = 1'b1; din[0] = 8'h19;
    tick(1);
    lv[0] = 1'b0;
    chk("w5_first_bit", {31'd0, dout[0]}, 32'd1);
    chk("w5_first_dv",  {31'd0, dv[0]},   32'd1);
    tick(8);
    chk("w5_nbits",  reccnt[0] - s_cnt, 32'd5);
    chk("w5_stream", {27'd0, rec[0][4:0]}, 32'h19);
    chk("w5_done",   wdcnt[0] - s_wd, 32'd1);
    chk("w5_detect", hits, 32'd1);
    chk("w5_idle",   {30'd0, dv[0], dout[0]}, 32'd0);

    // Back-to-back A5 then 3C, second word lands in the holding register.
    s_cnt = reccnt[1]; s_wd = wdcnt[1];
    lv[1] = 1'b1; din[1] = 8'hA5;
    tick(1);
    din[1] = 8'h3C;
    tick(1);
    lv[1] = 1'b0;
    chk("b2b_ready_low", {31'd0, lr[1]}, 32'd0);
    tick(25);
    chk("b2b_nbits",  reccnt[1] - s_cnt, 32'd16);
    chk("b2b_stream", {16'd0, rec[1][15:0]}, 32'hA53C);
    chk("b2b_done",   wdcnt[1] - s_wd, 32'd2);

    // 00 followed by FF offered exactly on the last-bit cycle.
    s_cnt = reccnt[1]; s_wd = wdcnt[1];
    lv[1] = 1'b1; din[1] = 8'h00;
    tick(1);
    lv[1] = 1'b0;
    tick(7);
    chk("direct_last_wd", {31'd0, wd[1]}, 32'd1);
    lv[1] = 1'b1; din[1] = 8'hFF;
    tick(1);
    lv[1] = 1'b0;
    chk("direct_first", {30'd0, dv[1], dout[1]}, 32'd3);
    tick(12);
    chk("direct_nbits",  reccnt[1] - s_cnt, 32'd16);
    chk("direct_stream", {16'd0, rec[1][15:0]}, 32'h00FF);
    chk("direct_done",   wdcnt[1] - s_wd, 32'd2);

    // Three words offered continuously under backpressure.
    w3[0] = 8'hC3; w3[1] = 8'h5A; w3[2] = 8'h96;
    s_cnt = reccnt[1]; s_wd = wdcnt[1];
    lv[1] = 1'b1; din[1] = w3[0];
    k = 0; cyc = 0;
    while (k < 3 && cyc < 100) begin
      rdy = lr[1];
      tick(1);
      cyc++;
      if (rdy) begin
        k++;
        if (k < 3) din[1] = w3[k];
        else lv[1] = 1'b0;
      end
    end
    lv[1] = 1'b0;
    chk("bp_all_accepted", k, 32'd3);
    tick(30);
    chk("bp_nbits",  reccnt[1] - s_cnt, 32'd24);
    chk("bp_stream", {8'd0, rec[1][23:0]}, 32'hC35A96);
    chk("bp_done",   wdcnt[1] - s_wd, 32'd3);

    // LSB-first instance.
    s_cnt = reccnt[2];
    lv[2] = 1'b1; din[2] = 8'h01;
    tick(1);
    lv[2] = 1'b0;
    tick(10);
    chk("lsb_nbits",  reccnt[2] - s_cnt, 32'd8);
    chk("lsb_stream", {24'd0, rec[2][7:0]}, 32'h80);

    // Asynchronous reset mid-word with the holding register full.
    lv[1] = 1'b1; din[1] = 8'hF0;
    tick(1);
    din[1] = 8'h0F;
    tick(1);
    lv[1] = 1'b0;
    tick(1);
    chk("pre_rst_busy", {31'd0, by[1]}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_dout",  {31'd0, dout[1]}, 32'd0);
    chk("arst_dv",    {31'd0, dv[1]},   32'd0);
    chk("arst_wd",    {31'd0, wd[1]},   32'd0);
    chk("arst_busy",  {31'd0, by[1]},   32'd0);
    chk("arst_ready", {31'd0, lr[1]},   32'd1);
    #10 rst = 1'b1;
    s_cnt = reccnt[1]; s_wd = wdcnt[1];
    tick(20);
    chk("post_rst_bits",  reccnt[1] - s_cnt, 32'd0);
    chk("post_rst_done",  wdcnt[1] - s_wd, 32'd0);
    chk("post_rst_ready", {31'd0, lr[1]}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
